// File: rtl/moore_seq.sv
// moore_seq: Moore 1011 detector with state/count status word; MOORE_SEQ_OVERLAP_EN selects overlapping detection
module moore_seq (
    input  logic       CK,
    input  logic       R,
    input  logic       IN,
    output logic [7:0] OUT
);
    typedef enum logic [2:0] {S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, S4 = 3'd4} state_t;
`ifdef MOORE_SEQ_OVERLAP_EN
    localparam state_t S4_ZERO = S2;
`else
    localparam state_t S4_ZERO = S0;
`endif
    state_t     state, nxt;
    logic [3:0] cnt;
    always_comb begin
        nxt = S0;
        case (state)
            S0:      nxt = IN ? S1 : S0;
            S1:      nxt = IN ? S1 : S2;
            S2:      nxt = IN ? S3 : S0;
            S3:      nxt = IN ? S4 : S2;
            S4:      nxt = IN ? S1 : S4_ZERO;
            default: nxt = S0;
        endcase
    end
    always_ff @(posedge CK) begin
        if (R) begin
            state <= S0;
            cnt   <= 4'd0;
        end else begin
            state <= nxt;
            if (nxt == S4) cnt <= cnt + 4'd1;
        end
    end
    assign OUT = {cnt, state, state == S4};
endmodule

// File: tb/tb_moore_seq.sv
// tb_moore_seq: directed self-checking bench for moore_seq
module tb_moore_seq;
    logic       CK = 1'b0;
    logic       R  = 1'b1;
    logic       IN = 1'b0;
    logic [7:0] OUT;
    int tests = 0;
    int fails = 0;

    moore_seq dut (.CK(CK), .R(R), .IN(IN), .OUT(OUT));

    always #5 CK = ~CK;

    logic       b_single[5] = '{1, 0, 1, 1, 0};
    logic       b_full[9]   = '{1, 0, 1, 1, 0, 1, 0, 1, 1};
    logic       b_ovl[7]    = '{1, 0, 1, 1, 0, 1, 1};
`ifdef MOORE_SEQ_OVERLAP_EN
    logic [7:0] e_single[5] = '{8'h02, 8'h04, 8'h06, 8'h19, 8'h14};
    logic [7:0] e_full[9]   = '{8'h02, 8'h04, 8'h06, 8'h19, 8'h14, 8'h16, 8'h14, 8'h16, 8'h29};
    logic [7:0] e_ovl[7]    = '{8'h02, 8'h04, 8'h06, 8'h19, 8'h14, 8'h16, 8'h29};
`else
    logic [7:0] e_single[5] = '{8'h02, 8'h04, 8'h06, 8'h19, 8'h10};
    logic [7:0] e_full[9]   = '{8'h02, 8'h04, 8'h06, 8'h19, 8'h10, 8'h12, 8'h14, 8'h16, 8'h29};
    logic [7:0] e_ovl[7]    = '{8'h02, 8'h04, 8'h06, 8'h19, 8'h10, 8'h12, 8'h12};
`endif
    logic       b_pat[4]    = '{1, 0, 1, 1};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r_i, input logic b, input logic [7:0] exp, input string tag);
        @(negedge CK);
        R  = r_i;
        IN = b;
        @(posedge CK);
        #1;
        check(tag, OUT, exp);
    endtask

    initial begin
        step(1'b1, 1'b1, 8'h00, "reset");
        step(1'b1, 1'b1, 8'h00, "reset_hold1");
        step(1'b1, 1'b0, 8'h00, "reset_hold2");
        for (int i = 0; i < 5; i++) step(1'b0, b_single[i], e_single[i], $sformatf("single[%0d]", i));
        step(1'b1, 1'b1, 8'h00, "reset_mid");
        for (int i = 0; i < 9; i++) step(1'b0, b_full[i], e_full[i], $sformatf("full[%0d]", i));
        step(1'b1, 1'b0, 8'h00, "reset_ovl");
        for (int i = 0; i < 7; i++) step(1'b0, b_ovl[i], e_ovl[i], $sformatf("ovl[%0d]", i));
        step(1'b1, 1'b0, 8'h00, "reset_wrap");
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge CK);
                R  = 1'b0;
                IN = b_pat[i];
            end
            step(1'b0, b_pat[3], {4'(k + 1), 4'h9}, $sformatf("wrap[%0d]", k));
        end
        step(1'b0, 1'b1, 8'h02, "post_wrap1");
        step(1'b0, 1'b0, 8'h04, "post_wrap0");
        step(1'b0, 1'b1, 8'h06, "post_wrap101");
        step(1'b1, 1'b1, 8'h00, "reset_partial");
        step(1'b0, 1'b1, 8'h02, "fresh_start");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
